arbiter_puf_engine: RTL and testbench

Multi-chain arbiter PUF with an on-chip evaluation sequencer. It runs N_CHAINS switch-box delay chains, each ending in an arbiter flop, under one challenge. Each chain is launched N_VOTES times; the block majority-votes each chain's bit and flags bits that did not respond the same way every time. It sits between the tile I/O wrapper and the challenge/response pins, and replaces the single-chain free-running arbiter with a clocked, handshaked engine.

---
 rtl/puf_pkg.sv | 31 +++
 rtl/arbiter_puf_engine_if.sv | 34 +++
 rtl/arbiter_chain.sv | 35 +++
 rtl/arbiter_puf_engine.sv | 154 +++++++++++++++
 tb/tb_arbiter_puf_engine.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/puf_pkg.sv
// ============================================================================
//  Module   : puf_pkg
//  Purpose  : State encoding, default parameters and challenge-rotation helper
//             shared by the arbiter PUF engine.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package puf_pkg;

    localparam int C_LENGTH_DEF      = 8;
    localparam int N_CHAINS_DEF      = 4;
    localparam int N_VOTES_DEF       = 5;
    localparam int SETTLE_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_SAMPLE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Source bit feeding bit 'idx' of a word rotated left by 'k'.
    function automatic int rotl_src(input int idx, input int k, input int width);
        return (idx + width - (k % width)) % width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arbiter_puf_engine_if.sv
// ============================================================================
//  Module   : arbiter_puf_engine_if
//  Purpose  : Start/challenge request and voted-response bundle of the PUF
//             engine. xor_out exists only when PUF_XOR_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arbiter_puf_engine_if #(
    parameter int C_LENGTH = 8,
    parameter int N_CHAINS = 4
);
    logic                start;
    logic [C_LENGTH-1:0] challenge;
    logic                busy;
    logic                valid;
    logic [N_CHAINS-1:0] response;
    logic [N_CHAINS-1:0] stable;
`ifdef PUF_XOR_EN
    logic                xor_out;

    modport master (output start, challenge,
                    input  busy, valid, response, stable, xor_out);
    modport slave  (input  start, challenge,
                    output busy, valid, response, stable, xor_out);
`else
    modport master (output start, challenge,
                    input  busy, valid, response, stable);
    modport slave  (input  start, challenge,
                    output busy, valid, response, stable);
`endif
endinterface

`default_nettype wire

// File: rtl/arbiter_chain.sv
// ============================================================================
//  Module   : arbiter_chain
//  Purpose  : One switch-box delay chain racing two copies of launch, ending
//             in an arbiter flop clocked by path A and sampling path B.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter_chain #(
    parameter int C_LENGTH = 8
) (
    input  wire logic                launch,
    input  wire logic [C_LENGTH-1:0] challenge,
    output logic                     arb_q
);

    logic [C_LENGTH:0] w_path_a;
    logic [C_LENGTH:0] w_path_b;

    assign w_path_a[0] = launch;
    assign w_path_b[0] = launch;

    // challenge bit 1 crosses the two paths, 0 passes them straight through
    for (genvar i = 0; i < C_LENGTH; i++) begin : g_stage
        assign w_path_a[i+1] = challenge[i] ? w_path_b[i] : w_path_a[i];
        assign w_path_b[i+1] = challenge[i] ? w_path_a[i] : w_path_b[i];
    end

    always_ff @(posedge w_path_a[C_LENGTH]) begin
        arb_q <= w_path_b[C_LENGTH];
    end

endmodule

`default_nettype wire

// File: rtl/arbiter_puf_engine.sv
// ============================================================================
//  Module   : arbiter_puf_engine
//  Purpose  : Multi-chain arbiter PUF with launch/sample/release sequencer and
//             per-chain majority voting. Optional XOR output: PUF_XOR_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter_puf_engine
    import puf_pkg::*;
#(
    parameter int C_LENGTH      = C_LENGTH_DEF,
    parameter int N_CHAINS      = N_CHAINS_DEF,
    parameter int N_VOTES       = N_VOTES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  wire logic           clk,
    input  wire logic           rst,
    arbiter_puf_engine_if.slave bus
);

    localparam int c_CNT_W  = $clog2(N_VOTES + 1);
    localparam int c_VIDX_W = (N_VOTES > 1) ? $clog2(N_VOTES) : 1;
    localparam int c_SET_W  = $clog2(SETTLE_CYCLES);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_launch;
    logic [c_SET_W-1:0]    r_settle;
    logic [c_VIDX_W-1:0]   r_vidx;
    logic [C_LENGTH-1:0]   r_chal;
    logic [N_CHAINS-1:0]   w_arb;
    logic [N_CHAINS-1:0]   r_sync1;
    logic [N_CHAINS-1:0]   r_sync2;
    logic [c_CNT_W-1:0]    r_votes [N_CHAINS];
    logic [N_CHAINS-1:0]   w_resp;
    logic [N_CHAINS-1:0]   w_stab;
    logic [N_CHAINS-1:0]   r_resp;
    logic [N_CHAINS-1:0]   r_stab;
    logic                  w_settle_done;
    logic                  w_last_vote;
    logic                  w_busy;
    logic                  w_valid;

    assign w_settle_done = (r_settle == c_SET_W'(SETTLE_CYCLES - 1));
    assign w_last_vote   = (r_vidx == c_VIDX_W'(N_VOTES - 1));

    for (genvar k = 0; k < N_CHAINS; k++) begin : g_chain
        logic [C_LENGTH-1:0] w_chal;
        for (genvar i = 0; i < C_LENGTH; i++) begin : g_bit
            assign w_chal[i] = r_chal[rotl_src(i, k, C_LENGTH)];
        end
        (* dont_touch = "true" *)
        arbiter_chain #(.C_LENGTH(C_LENGTH)) u_chain (
            .launch    (r_launch),
            .challenge (w_chal),
            .arb_q     (w_arb[k])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_valid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) w_state_nxt = ST_LAUNCH;
            end
            ST_LAUNCH:  if (w_settle_done) w_state_nxt = ST_SAMPLE;
            ST_SAMPLE:  w_state_nxt = ST_RELEASE;
            ST_RELEASE: if (w_settle_done) w_state_nxt = w_last_vote ? ST_DONE : ST_LAUNCH;
            ST_DONE: begin
                w_busy      = 1'b0;
                w_valid     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_resp = '0;
        w_stab = '0;
        for (int k = 0; k < N_CHAINS; k++) begin
            w_resp[k] = (r_votes[k] > c_CNT_W'(N_VOTES / 2));
            w_stab[k] = (r_votes[k] == '0) || (r_votes[k] == c_CNT_W'(N_VOTES));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_launch <= 1'b0;
            r_settle <= '0;
            r_vidx   <= '0;
            r_chal   <= '0;
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_resp   <= '0;
            r_stab   <= '0;
            for (int k = 0; k < N_CHAINS; k++) r_votes[k] <= '0;
        end else begin
            r_state  <= w_state_nxt;
            // registered so the chains see a glitch-free launch edge
            r_launch <= (w_state_nxt == ST_LAUNCH);
            r_sync1  <= w_arb;
            r_sync2  <= r_sync1;

            if ((r_state == ST_LAUNCH || r_state == ST_RELEASE) && (w_state_nxt == r_state))
                r_settle <= r_settle + c_SET_W'(1);
            else
                r_settle <= '0;

            if (r_state == ST_IDLE && bus.start) begin
                r_chal <= bus.challenge;
                r_vidx <= '0;
                for (int k = 0; k < N_CHAINS; k++) r_votes[k] <= '0;
            end else if (r_state == ST_SAMPLE) begin
                for (int k = 0; k < N_CHAINS; k++)
                    r_votes[k] <= r_votes[k] + c_CNT_W'(r_sync2[k]);
            end

            if (r_state == ST_RELEASE && w_settle_done && !w_last_vote)
                r_vidx <= r_vidx + c_VIDX_W'(1);

            if (w_state_nxt == ST_DONE && r_state != ST_DONE) begin
                r_resp <= w_resp;
                r_stab <= w_stab;
            end
        end
    end

`ifdef PUF_XOR_EN
    logic r_xor;

    always_ff @(posedge clk) begin
        if (rst)
            r_xor <= 1'b0;
        else if (w_state_nxt == ST_DONE && r_state != ST_DONE)
            r_xor <= ^w_resp;
    end

    assign bus.xor_out = r_xor;
`endif

    assign bus.busy     = w_busy;
    assign bus.valid    = w_valid;
    assign bus.response = r_resp;
    assign bus.stable   = r_stab;

endmodule

`default_nettype wire

// File: tb/tb_arbiter_puf_engine.sv
// ============================================================================
//  Module   : tb_arbiter_puf_engine
//  Purpose  : Scoreboard bench for arbiter_puf_engine with forced arbiter
//             outputs. Checks xor_out too when PUF_XOR_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arbiter_puf_engine;

    localparam int C_LENGTH      = 8;
    localparam int N_CHAINS      = 4;
    localparam int N_VOTES       = 5;
    localparam int SETTLE_CYCLES = 4;
    localparam int ROUND         = 2 * SETTLE_CYCLES + 1;
    // edges from the accepting edge to the edge that enters DONE
    localparam int LAT           = N_VOTES * ROUND;

    typedef struct {
        logic [N_CHAINS-1:0] resp;
        logic [N_CHAINS-1:0] stab;
        logic                x;
        int                  cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    exp_t                q[$];
    exp_t                mon_e;
    logic [N_CHAINS-1:0] vote_tab [N_VOTES];
    logic [N_CHAINS-1:0] arb_val;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    arbiter_puf_engine_if #(.C_LENGTH(C_LENGTH), .N_CHAINS(N_CHAINS)) bus ();

    arbiter_puf_engine #(
        .C_LENGTH      (C_LENGTH),
        .N_CHAINS      (N_CHAINS),
        .N_VOTES       (N_VOTES),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_arb(input logic [N_CHAINS-1:0] v);
        arb_val = v;
        force dut.g_chain[0].u_chain.arb_q = arb_val[0];
        force dut.g_chain[1].u_chain.arb_q = arb_val[1];
        force dut.g_chain[2].u_chain.arb_q = arb_val[2];
        force dut.g_chain[3].u_chain.arb_q = arb_val[3];
    endtask

    // Reference: count the samples each chain produced, then vote.
    task automatic model(output exp_t e);
        int cnt;
        e.resp = '0;
        e.stab = '0;
        for (int k = 0; k < N_CHAINS; k++) begin
            cnt = 0;
            for (int v = 0; v < N_VOTES; v++) cnt += int'(vote_tab[v][k]);
            e.resp[k] = (2 * cnt > N_VOTES);
            e.stab[k] = (cnt == 0) || (cnt == N_VOTES);
        end
        e.x   = ^e.resp;
        e.cyc = 0;
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] c, input int k);
        logic [15:0] d;
        d = {c, c} << k;
        return d[15:8];
    endfunction

    task automatic check_rot(input logic [7:0] ch);
        check("rot_chain0", 32'(dut.g_chain[0].u_chain.challenge), 32'(rotl8(ch, 0)));
        check("rot_chain1", 32'(dut.g_chain[1].u_chain.challenge), 32'(rotl8(ch, 1)));
        check("rot_chain2", 32'(dut.g_chain[2].u_chain.challenge), 32'(rotl8(ch, 2)));
        check("rot_chain3", 32'(dut.g_chain[3].u_chain.challenge), 32'(rotl8(ch, 3)));
    endtask

    // pulse: extra start while busy; hold: start kept high for a back-to-back run
    task automatic run_eval(input logic [7:0] ch, input bit pulse, input bit hold);
        exp_t e;
        int   t;
        int   total;
        model(e);
        @(negedge clk);
        bus.challenge = ch;
        bus.start     = 1'b1;
        set_arb(vote_tab[0]);
        @(posedge clk);
        #1;
        t = cyc;
        bus.start = hold;
        e.cyc = t + LAT;
        q.push_back(e);
        if (hold) begin
            e.cyc = t + 2 * LAT + 2;
            q.push_back(e);
        end
        check_rot(ch);
        total = hold ? 2 * LAT + 3 : LAT + 1;
        for (int n = 1; n <= total; n++) begin
            @(posedge clk);
            #1;
            if ((n % ROUND) == 0 && (n / ROUND) < N_VOTES) set_arb(vote_tab[n / ROUND]);
            bus.start = hold ? (n < LAT + 2) : (pulse && n == ROUND);
        end
        bus.start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: valid=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                mon_e = q.pop_front();
                check("valid_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("response", 32'(bus.response), 32'(mon_e.resp));
                check("stable", 32'(bus.stable), 32'(mon_e.stab));
                check("busy_at_valid", 32'(bus.busy), 32'd0);
`ifdef PUF_XOR_EN
                check("xor_out", 32'(bus.xor_out), 32'(mon_e.x));
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start     = 1'b0;
        bus.challenge = '0;
        set_arb('0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_valid", 32'(bus.valid), 32'd0);
        check("reset_response", 32'(bus.response), 32'd0);
        check("reset_stable", 32'(bus.stable), 32'd0);
`ifdef PUF_XOR_EN
        check("reset_xor", 32'(bus.xor_out), 32'd0);
`endif
        rst = 1'b0;

        // latency with a constant pattern
        for (int v = 0; v < N_VOTES; v++) vote_tab[v] = 4'b1010;
        run_eval(8'h5A, 1'b0, 1'b0);

        // reset in the middle of LAUNCH
        @(negedge clk);
        bus.challenge = 8'hC3;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_valid", 32'(bus.valid), 32'd0);
        check("midrst_response", 32'(bus.response), 32'd0);
        check("midrst_stable", 32'(bus.stable), 32'd0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("idle_holds_busy", 32'(bus.busy), 32'd0);

        // chain 0 votes 1,1,0,1,0; other chains 0
        vote_tab[0] = 4'b0001;
        vote_tab[1] = 4'b0001;
        vote_tab[2] = 4'b0000;
        vote_tab[3] = 4'b0001;
        vote_tab[4] = 4'b0000;
        run_eval(8'h3C, 1'b0, 1'b0);

        // rotation check plus a start pulse while busy
        for (int v = 0; v < N_VOTES; v++) vote_tab[v] = 4'($urandom_range(0, 15));
        run_eval(8'h81, 1'b1, 1'b0);

        // start held high: two evaluations back to back
        for (int v = 0; v < N_VOTES; v++) vote_tab[v] = 4'b0111;
        run_eval(8'hE7, 1'b0, 1'b1);

        // randomized evaluations
        for (int r = 0; r < 8; r++) begin
            for (int v = 0; v < N_VOTES; v++) vote_tab[v] = '0;
            for (int k = 0; k < N_CHAINS; k++) begin
                int mode;
                mode = int'($urandom_range(0, 2));
                for (int v = 0; v < N_VOTES; v++)
                    vote_tab[v][k] = (mode == 0) ? 1'b0 :
                                     (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            run_eval(8'($urandom), 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL missing_valid: %0d responses outstanding, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
